apb_to_uart: RTL and testbench

//  APB3/APB4 slave bridging a CPU bus to a full-duplex 8N1 UART.

---
 rtl/apb_to_uart_pkg.sv | 29 ++
 rtl/uart_fifo.sv | 50 +++++
 rtl/apb_to_uart.sv | 258 +++++++++++++++++++++++++
 tb/tb_apb_to_uart.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_to_uart_pkg.sv
// rtl/apb_to_uart_pkg.sv - shared register indices, status bit positions and FSM state types
package apb_to_uart_pkg;

    localparam logic [1:0] REG_TX      = 2'd0;
    localparam logic [1:0] REG_RX_STAT = 2'd1;
    localparam logic [1:0] REG_RX_DATA = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int ST_AEMPTY  = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_AFULL   = 2;
    localparam int ST_FULL    = 3;
    localparam int ST_OVERRUN = 4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // One-hot fill level; counts between the named levels report 0.
    function automatic logic [3:0] fifo_status(input int unsigned cnt, input int unsigned depth);
        logic [3:0] s;
        s            = '0;
        s[ST_FULL]   = (cnt == depth);
        s[ST_AFULL]  = (cnt == depth - 1);
        s[ST_EMPTY]  = (cnt == 0);
        s[ST_AEMPTY] = (cnt == 1);
        return s;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO with occupancy count
// Ports: clk, arst (async, active-high); wr_en/wr_data push; rd_en pops;
//        rd_data shows the head entry; count/full/empty report occupancy.
// A pop and a push in the same cycle are both honoured even when full.
module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push, do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = rd_en & ~empty;
    assign do_push = wr_en & (~full | do_pop);
    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      cnt <= cnt + (AW+1)'(1);
            else if (do_pop && !do_push) cnt <= cnt - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/apb_to_uart.sv
// rtl/apb_to_uart.sv - APB slave bridging to an 8N1 UART with TX/RX FIFOs
// Ports: clk, arst (async, active-high); rx/tx serial lines (idle high);
//        APB slave paddr/pprot/psel/penable/pwrite/pwdata/pstrb -> pready/prdata/pslverr.
// Registers (byte offset from BASE_ADDR): 0 TX status / TX push, 1 RX status
// (bit4 sticky overrun, read-to-clear), 2 RX data pop, 3 control (loopback).
// Build option UART_LOOPBACK_EN: enables the control register and TX->RX loopback;
// without it offset 3 returns an error.
module apb_to_uart
    import apb_to_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'd0,
    parameter int          FIFO_DEPTH = 16,
    parameter int          BAUDRATE   = 9600,
    parameter int          CLK_FREQ   = 100000000
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        rx,
    output logic        tx,
    input  logic [31:0] paddr,
    input  logic [2:0]  pprot,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr
);
    localparam int          DIV       = CLK_FREQ / BAUDRATE;
    localparam logic [31:0] DIV_LAST  = 32'(DIV - 1);
    localparam logic [31:0] HALF_LAST = 32'(DIV / 2 - 1);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;

    logic unused_ok;
    assign unused_ok = ^{pprot, pstrb, pwdata[31:8]};

    // ---------------- APB decode ----------------
    logic [31:0] off, rdata;
    logic [1:0]  idx;
    logic        access, in_range, err;
    logic        tx_push, rx_pop, ovr_clr, overrun, ovr_set;
    logic [7:0]  tx_fdata, rx_fdata, rx_byte;
    logic [CW-1:0] tx_count, rx_count;
    logic        tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_push;
    logic [3:0]  tx_stat, rx_stat;
    logic        rx_src, tx_line;

    assign off      = paddr - BASE_ADDR;
    assign idx      = off[1:0];
    assign in_range = (off < 32'd4);
    assign access   = psel & penable;
    assign tx_stat  = fifo_status(int'(tx_count), FIFO_DEPTH);
    assign rx_stat  = fifo_status(int'(rx_count), FIFO_DEPTH);

`ifdef UART_LOOPBACK_EN
    logic loopback;
`endif

    always_comb begin
        rdata = '0;
        err   = 1'b0;
        if (!in_range) begin
            err = 1'b1;
        end else begin
            case (idx)
                REG_TX:      if (pwrite) err = tx_full; else rdata = {28'd0, tx_stat};
                REG_RX_STAT: if (pwrite) err = 1'b1;    else rdata = {27'd0, overrun, rx_stat};
                REG_RX_DATA: if (pwrite || rx_empty) err = 1'b1; else rdata = {24'd0, rx_fdata};
                REG_CTRL: begin
`ifdef UART_LOOPBACK_EN
                    if (!pwrite) rdata = {31'd0, loopback};
`else
                    err = 1'b1;
`endif
                end
                default: err = 1'b1;
            endcase
        end
    end

    assign pready  = 1'b1;
    assign prdata  = access ? rdata : 32'd0;
    assign pslverr = access & err;
    assign tx_push = access & in_range & ~err & pwrite  & (idx == REG_TX);
    assign rx_pop  = access & in_range & ~err & ~pwrite & (idx == REG_RX_DATA);
    assign ovr_clr = access & in_range & ~pwrite & (idx == REG_RX_STAT);

`ifdef UART_LOOPBACK_EN
    always_ff @(posedge clk or posedge arst) begin
        if (arst) loopback <= 1'b0;
        else if (access & in_range & ~err & pwrite & (idx == REG_CTRL)) loopback <= pwdata[0];
    end
    assign rx_src = loopback ? tx_line : rx;
    assign tx     = loopback ? 1'b1 : tx_line;
`else
    assign rx_src = rx;
    assign tx     = tx_line;
`endif

    // Set wins over the clearing read so a same-cycle overrun is not lost.
    always_ff @(posedge clk or posedge arst) begin
        if (arst)         overrun <= 1'b0;
        else if (ovr_set) overrun <= 1'b1;
        else if (ovr_clr) overrun <= 1'b0;
    end

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk(clk), .arst(arst), .wr_en(tx_push), .wr_data(pwdata[7:0]), .rd_en(tx_pop),
        .rd_data(tx_fdata), .count(tx_count), .full(tx_full), .empty(tx_empty)
    );

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk(clk), .arst(arst), .wr_en(rx_push), .wr_data(rx_byte), .rd_en(rx_pop),
        .rd_data(rx_fdata), .count(rx_count), .full(rx_full), .empty(rx_empty)
    );

    // ---------------- TX ----------------
    tx_state_t   tx_state, tx_state_n;
    logic [31:0] tx_cnt, tx_cnt_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_sh, tx_sh_n;
    logic        tx_line_n;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
            tx_line  <= tx_line_n;
        end
    end

    // tx_line is registered: each state drives the level of the bit it is timing.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 32'd1;
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        tx_line_n  = tx_line;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n  = '0;
                tx_line_n = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_sh_n    = tx_fdata;
                    tx_line_n  = 1'b0;
                    tx_state_n = TX_START;
                end
            end
            TX_START: if (tx_cnt == DIV_LAST) begin
                tx_cnt_n   = '0;
                tx_bit_n   = '0;
                tx_line_n  = tx_sh[0];
                tx_state_n = TX_DATA;
            end
            TX_DATA: if (tx_cnt == DIV_LAST) begin
                tx_cnt_n = '0;
                if (tx_bit == 3'd7) begin
                    tx_line_n  = 1'b1;
                    tx_state_n = TX_STOP;
                end else begin
                    tx_bit_n  = tx_bit + 3'd1;
                    tx_sh_n   = {1'b0, tx_sh[7:1]};
                    tx_line_n = tx_sh[1];
                end
            end
            TX_STOP: if (tx_cnt == DIV_LAST) begin
                tx_cnt_n = '0;
                // Chain straight into the next start bit when data is waiting.
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_sh_n    = tx_fdata;
                    tx_line_n  = 1'b0;
                    tx_state_n = TX_START;
                end else begin
                    tx_line_n  = 1'b1;
                    tx_state_n = TX_IDLE;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // ---------------- RX ----------------
    rx_state_t   rx_state, rx_state_n;
    logic [31:0] rx_cnt, rx_cnt_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_byte_n;
    logic        rx_meta, rx_s, rx_prev;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_byte  <= '0;
        end else begin
            rx_meta  <= rx_src;
            rx_s     <= rx_meta;
            rx_prev  <= rx_s;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_byte  <= rx_byte_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 32'd1;
        rx_bit_n   = rx_bit;
        rx_byte_n  = rx_byte;
        rx_push    = 1'b0;
        ovr_set    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_s) rx_state_n = RX_START;
            end
            // Half a bit in: still low means a real start bit, else a glitch.
            RX_START: if (rx_cnt == HALF_LAST) begin
                rx_cnt_n   = '0;
                rx_bit_n   = '0;
                rx_state_n = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt == DIV_LAST) begin
                rx_cnt_n  = '0;
                rx_byte_n = {rx_s, rx_byte[7:1]};
                if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                else                rx_bit_n   = rx_bit + 3'd1;
            end
            RX_STOP: if (rx_cnt == DIV_LAST) begin
                rx_cnt_n   = '0;
                rx_state_n = RX_IDLE;
                if (rx_s) begin
                    if (rx_full && !rx_pop) ovr_set = 1'b1;
                    else                    rx_push = 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_to_uart.sv
// tb/tb_apb_to_uart.sv - directed self-checking bench for apb_to_uart
module tb_apb_to_uart;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int DIV = 16;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        rx = 1'b1;
    logic        tx;
    logic [31:0] paddr = '0;
    logic [2:0]  pprot = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = 4'hF;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int n_pass = 0;
    int n_total = 0;
    logic [8:0] tx_q[$];

    apb_to_uart #(.BASE_ADDR(BASE), .FIFO_DEPTH(16), .BAUDRATE(9600), .CLK_FREQ(9600 * DIV)) dut (
        .clk(clk), .arst(arst), .rx(rx), .tx(tx), .paddr(paddr), .pprot(pprot),
        .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    // Decodes every frame seen on tx as {stop, data}.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge tx);
            repeat (DIV / 2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(posedge clk);
                #1 b[i] = tx;
            end
            repeat (DIV) @(posedge clk);
            #1 tx_q.push_back({tx, b});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic apb(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
        @(negedge clk);
        paddr = addr; pwrite = wr; pwdata = wd; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1 rd = prdata; er = pslverr;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk) rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;

        // Reset
        repeat (3) @(negedge clk);
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_prdata", prdata, 32'd0);
        chk("reset_pslverr", {31'd0, pslverr}, 32'd0);
        arst = 1'b0;
        apb(BASE + 0, 1'b0, 0, rd, er);
        chk("tx_stat_reset", rd, 32'h2);
        apb(BASE + 1, 1'b0, 0, rd, er);
        chk("rx_stat_reset", rd, 32'h2);
        chk("rx_stat_reset_err", {31'd0, er}, 32'd0);

        // Decode errors
        apb(BASE + 1, 1'b1, 32'h55, rd, er);
        chk("wr_idx1_err", {31'd0, er}, 32'd1);
        apb(BASE + 2, 1'b1, 32'h55, rd, er);
        chk("wr_idx2_err", {31'd0, er}, 32'd1);
        apb(BASE + 8, 1'b0, 0, rd, er);
        chk("rd_oor_err", {31'd0, er}, 32'd1);
        chk("rd_oor_data", rd, 32'd0);
        apb(BASE + 8, 1'b1, 32'h77, rd, er);
        chk("wr_oor_err", {31'd0, er}, 32'd1);
        apb(BASE + 3, 1'b0, 0, rd, er);
`ifdef UART_LOOPBACK_EN
        chk("rd_ctrl_err", {31'd0, er}, 32'd0);
`else
        chk("rd_idx3_err", {31'd0, er}, 32'd1);
`endif
        chk("rd_idx3_data", rd, 32'd0);
        apb(BASE + 2, 1'b0, 0, rd, er);
        chk("rx_empty_rd_err", {31'd0, er}, 32'd1);
        chk("rx_empty_rd_data", rd, 32'd0);
        apb(BASE + 1, 1'b0, 0, rd, er);
        chk("rx_stat_after_decode", rd, 32'h2);

        // TX: first byte goes straight to the shifter, the next 16 fill the FIFO
        for (int i = 0; i < 17; i++) begin
            apb(BASE + 0, 1'b1, i, rd, er);
            chk($sformatf("tx_push_err[%0d]", i), {31'd0, er}, 32'd0);
        end
        apb(BASE + 0, 1'b0, 0, rd, er);
        chk("tx_stat_full", rd, 32'h8);
        apb(BASE + 0, 1'b1, 32'hEE, rd, er);
        chk("tx_push_full_err", {31'd0, er}, 32'd1);
        for (int k = 0; k < 4000 && tx_q.size() < 17; k++) @(posedge clk);
        chk("tx_frame_count", tx_q.size(), 32'd17);
        for (int i = 0; i < 17 && i < tx_q.size(); i++)
            chk($sformatf("tx_frame[%0d]", i), {23'd0, tx_q[i]}, 32'h100 | i);
        repeat (300) @(posedge clk);
        chk("tx_no_extra_frame", tx_q.size(), 32'd17);
        apb(BASE + 0, 1'b0, 0, rd, er);
        chk("tx_stat_drained", rd, 32'h2);

        // RX: fill, overrun, drain
        for (int i = 0; i < 16; i++) send_frame(8'(100 + i), 1'b1);
        apb(BASE + 1, 1'b0, 0, rd, er);
        chk("rx_stat_full", rd, 32'h8);
        send_frame(8'd200, 1'b1);
        apb(BASE + 1, 1'b0, 0, rd, er);
        chk("rx_stat_overrun", rd, 32'h18);
        apb(BASE + 1, 1'b0, 0, rd, er);
        chk("rx_stat_ovr_cleared", rd, 32'h08);
        for (int i = 0; i < 16; i++) begin
            apb(BASE + 2, 1'b0, 0, rd, er);
            chk($sformatf("rx_data[%0d]", i), rd, 32'(100 + i));
            chk($sformatf("rx_data_err[%0d]", i), {31'd0, er}, 32'd0);
            if (i == 0) begin
                apb(BASE + 1, 1'b0, 0, rd, er);
                chk("rx_stat_afull", rd, 32'h4);
            end
            if (i == 14) begin
                apb(BASE + 1, 1'b0, 0, rd, er);
                chk("rx_stat_aempty", rd, 32'h1);
            end
        end
        apb(BASE + 1, 1'b0, 0, rd, er);
        chk("rx_stat_drained", rd, 32'h2);
        apb(BASE + 2, 1'b0, 0, rd, er);
        chk("rx_empty_rd_err2", {31'd0, er}, 32'd1);
        chk("rx_empty_rd_data2", rd, 32'd0);

        // Frame faults
        send_frame(8'h3C, 1'b0);
        repeat (2 * DIV) @(negedge clk);
        apb(BASE + 1, 1'b0, 0, rd, er);
        chk("rx_framing_no_push", rd, 32'h2);
        @(negedge clk) rx = 1'b0;
        @(negedge clk) rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        apb(BASE + 1, 1'b0, 0, rd, er);
        chk("rx_glitch_no_frame", rd, 32'h2);
        send_frame(8'h5A, 1'b1);
        apb(BASE + 1, 1'b0, 0, rd, er);
        chk("rx_stat_one", rd, 32'h1);
        apb(BASE + 2, 1'b0, 0, rd, er);
        chk("rx_data_after_faults", rd, 32'h5A);

`ifdef UART_LOOPBACK_EN
        apb(BASE + 3, 1'b1, 32'h1, rd, er);
        chk("ctrl_wr_err", {31'd0, er}, 32'd0);
        apb(BASE + 3, 1'b0, 0, rd, er);
        chk("ctrl_rd", rd, 32'h1);
        apb(BASE + 0, 1'b1, 32'hA5, rd, er);
        repeat (12 * DIV) @(posedge clk);
        apb(BASE + 2, 1'b0, 0, rd, er);
        chk("loopback_data", rd, 32'hA5);
        chk("loopback_tx_quiet", tx_q.size(), 32'd17);
        apb(BASE + 3, 1'b1, 32'h0, rd, er);
`endif

        // Async reset mid-frame
        apb(BASE + 0, 1'b1, 32'h81, rd, er);
        repeat (40) @(posedge clk);
        #3 arst = 1'b1;
        #1 chk("tx_async_reset", {31'd0, tx}, 32'd1);
        repeat (2) @(negedge clk);
        arst = 1'b0;
        apb(BASE + 0, 1'b0, 0, rd, er);
        chk("tx_stat_after_reset", rd, 32'h2);
        chk("tx_idle_after_reset", {31'd0, tx}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
